// File: rtl/seq_alu.sv
`timescale 1ns/1ps
// seq_alu: multi-cycle integer ALU for the execute stage.
// Optional SEQ_ALU_DIVZ_TRAP_EN adds a div_zero output and fast div-by-zero.
module seq_alu #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       alu_op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             v,
   output logic             c,
   output logic             z,
   output logic             s
`ifdef SEQ_ALU_DIVZ_TRAP_EN
   ,
   output logic             div_zero
`endif
);
   localparam int CW = $clog2(WIDTH);
   localparam int W2 = 2 * WIDTH;
   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_MUL = 3'd2;
   localparam logic [2:0] OP_DIV = 3'd3;
   localparam logic [2:0] OP_AND = 3'd4;
   localparam logic [2:0] OP_OR  = 3'd5;
   localparam logic [2:0] OP_XOR = 3'd6;
   localparam logic [2:0] OP_REM = 3'd7;
   localparam logic [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t state, state_nx;
   logic accept, fast, divz, last, ld_en;
   logic [CW-1:0] cnt;
   logic [2:0] op_q;
   logic [WIDTH-1:0] a_q, b_q, a_mag, b_mag;
   logic [W2-1:0] acc, mc, acc_n, full;
   logic [WIDTH-1:0] mp, dv, rem_r, r_n, q_n;
   logic [WIDTH:0] r_sh, trial, sum, dif;
   logic [WIDTH-1:0] f_res, c_res, ld_res;
   logic f_v, f_c, c_v, ld_v, ld_c;

   assign in_ready  = (state == IDLE) && !reset;
   assign out_valid = (state == DONE);
   assign accept    = in_valid && in_ready;
   assign fast      = (alu_op == OP_ADD) || (alu_op == OP_SUB) ||
                      (alu_op == OP_AND) || (alu_op == OP_OR) ||
                      (alu_op == OP_XOR);
`ifdef SEQ_ALU_DIVZ_TRAP_EN
   assign divz = ((alu_op == OP_DIV) || (alu_op == OP_REM)) && (b == '0);
`else
   assign divz = 1'b0;
`endif
   assign last  = (cnt == CW'(WIDTH - 1));
   assign a_mag = a[WIDTH-1] ? -a : a;
   assign b_mag = b[WIDTH-1] ? -b : b;
   assign ld_en = (accept && (fast || divz)) || ((state == CALC) && last);

   // state register
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   // next-state logic
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (accept) state_nx = (fast || divz) ? DONE : CALC;
         CALC:    if (last) state_nx = DONE;
         DONE:    if (out_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // single-cycle ops straight from the presented operands
   always_comb begin
      sum   = {1'b0, a} + {1'b0, b};
      dif   = {1'b0, a} - {1'b0, b};
      f_res = '0;
      f_v   = 1'b0;
      f_c   = 1'b0;
      unique case (alu_op)
         OP_ADD: begin
            f_res = sum[WIDTH-1:0];
            f_c   = sum[WIDTH];
            f_v   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB: begin
            f_res = dif[WIDTH-1:0];
            f_c   = dif[WIDTH];
            f_v   = (a[WIDTH-1] != b[WIDTH-1]) && (dif[WIDTH-1] != a[WIDTH-1]);
         end
         OP_AND: f_res = a & b;
         OP_OR:  f_res = a | b;
         OP_XOR: f_res = a ^ b;
         OP_DIV: begin
            f_res = '1;
            f_v   = 1'b1;
         end
         OP_REM: begin
            f_res = a;
            f_v   = 1'b1;
         end
         default: f_res = '0;
      endcase
   end

   // one shift-add / restoring-divide step
   always_comb begin
      acc_n = acc;
      if (mp[0]) acc_n = acc + mc;
      r_sh  = {rem_r, mp[WIDTH-1]};
      trial = r_sh - {1'b0, dv};
      if (!trial[WIDTH]) begin
         r_n = trial[WIDTH-1:0];
         q_n = {mp[WIDTH-2:0], 1'b1};
      end else begin
         r_n = r_sh[WIDTH-1:0];
         q_n = {mp[WIDTH-2:0], 1'b0};
      end
   end

   // sign fix-up and flags for the iterative ops
   always_comb begin
      full  = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) ? -acc_n : acc_n;
      c_res = '0;
      c_v   = 1'b0;
      unique case (op_q)
         OP_MUL: begin
            c_res = full[WIDTH-1:0];
            c_v   = !((&full[W2-1:WIDTH-1]) || !(|full[W2-1:WIDTH-1]));
         end
         OP_DIV: begin
            if (b_q == '0) begin
               c_res = '1;
               c_v   = 1'b1;
            end else begin
               c_res = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) ? -q_n : q_n;
               c_v   = (a_q == MINV) && (b_q == '1);
            end
         end
         default: begin
            if (b_q == '0) begin
               c_res = a_q;
               c_v   = 1'b1;
            end else begin
               c_res = a_q[WIDTH-1] ? -r_n : r_n;
            end
         end
      endcase
   end

   // pick which path loads the output registers
   always_comb begin
      ld_res = f_res;
      ld_v   = f_v;
      ld_c   = f_c;
      if (state == CALC) begin
         ld_res = c_res;
         ld_v   = c_v;
         ld_c   = 1'b0;
      end
   end

   // operand capture, iteration and registered result/flags
   always_ff @(posedge clk) begin
      if (reset) begin
         result <= '0;
         v      <= 1'b0;
         c      <= 1'b0;
         z      <= 1'b0;
         s      <= 1'b0;
         cnt    <= '0;
      end else begin
         if (ld_en) begin
            result <= ld_res;
            v      <= ld_v;
            c      <= ld_c;
            z      <= (ld_res == '0);
            s      <= ld_res[WIDTH-1];
         end
         if (accept) begin
            a_q   <= a;
            b_q   <= b;
            op_q  <= alu_op;
            cnt   <= '0;
            acc   <= '0;
            rem_r <= '0;
            mc    <= {{WIDTH{1'b0}}, a_mag};
            mp    <= (alu_op == OP_MUL) ? b_mag : a_mag;
            dv    <= b_mag;
         end else if (state == CALC) begin
            cnt <= cnt + 1'b1;
            if (op_q == OP_MUL) begin
               acc <= acc_n;
               mc  <= mc << 1;
               mp  <= mp >> 1;
            end else begin
               rem_r <= r_n;
               mp    <= q_n;
            end
         end
      end
   end

`ifdef SEQ_ALU_DIVZ_TRAP_EN
   // divide-by-zero indication travels with the result
   always_ff @(posedge clk) begin
      if (reset)      div_zero <= 1'b0;
      else if (ld_en) div_zero <= (state != CALC) && divz;
   end
`endif

endmodule
